// File: rtl/fdtd_calc_hy.sv
// ---------------------------------------------------------------------------
// fdtd_calc_hy
// Streaming 1-D FDTD magnetic-field update:
//   Hy_new[k] = chyh*Hy_old[k] + chyez*(Ez[k+1] - Ez[k])
// One grid line arrives as (Ez_new, Hy_old) beats. Each beat is parked in a
// hold register until its right-hand Ez neighbour arrives. The line is closed
// with a PEC boundary (Ez[LINE_LEN] = 0) by a flush operation.
// Pipeline: issue -> S1 (saturating difference) -> S2 (full products)
//           -> S3 (slice, add, saturate; output register).
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake, in_last marks the final beat of a line
//   Ez_i, Hy_old_i      Ez[k] (already updated) and Hy[k] of the previous step
//   chyh, chyez         coefficients, 2^CUT_RT represents 1.0
//   out_valid/out_ready output handshake, out_last marks Hy[last]
//   Hy_n_o              Hy_new[k]
//   line_err            sticky: in_last position disagrees with LINE_LEN
// ---------------------------------------------------------------------------
module fdtd_calc_hy #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int CUT_LT          = 51,
    parameter int CUT_RT          = 21,
    parameter int LINE_LEN        = 64
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [FDTD_DATA_WIDTH-1:0] Ez_i,
    input  logic [FDTD_DATA_WIDTH-1:0] Hy_old_i,
    input  logic [FDTD_DATA_WIDTH-1:0] chyh,
    input  logic [FDTD_DATA_WIDTH-1:0] chyez,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [FDTD_DATA_WIDTH-1:0] Hy_n_o,
    output logic                       line_err
);

    localparam int W  = FDTD_DATA_WIDTH;
    localparam int CW = $clog2(LINE_LEN);

    // The product slice plus the product sign bit must form exactly W bits.
    if (CUT_LT - CUT_RT + 2 != W) begin : g_bad_cut
        $error("fdtd_calc_hy: CUT_LT-CUT_RT+2 must equal FDTD_DATA_WIDTH");
    end

    // Clamp a (W+1)-bit two's complement value into W bits.
    function automatic logic [W-1:0] sat_w(input logic [W:0] v);
        logic [W-1:0] r;
        if (v[W] != v[W-1]) begin
            r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

    // Keep the product sign plus the fixed-point slice of a 2W-bit product.
    function automatic logic [W-1:0] trunc_p(input logic [2*W-1:0] p);
        return {p[2*W-1], p[CUT_LT:CUT_RT]};
    endfunction

    // Hold stage and line control
    logic          r_hold_vld;
    logic [W-1:0]  r_ez_h;
    logic [W-1:0]  r_hy_h;
    logic [CW-1:0] r_cnt;
    logic          r_flush_pending;
    logic          r_line_err;

    // Issue stage
    logic          r_is_vld;
    logic          r_is_last;
    logic [W-1:0]  r_is_ezr;
    logic [W-1:0]  r_is_ezh;
    logic [W-1:0]  r_is_hy;

    // S1
    logic          r_s1_vld;
    logic          r_s1_last;
    logic [W-1:0]  r_s1_d;
    logic [W-1:0]  r_s1_hy;

    // S2
    logic            r_s2_vld;
    logic            r_s2_last;
    logic [2*W-1:0]  r_s2_p0;
    logic [2*W-1:0]  r_s2_p1;

    // S3 / outputs
    logic          r_out_valid;
    logic          r_out_last;
    logic [W-1:0]  r_hy_n;

    logic           w_adv;
    logic           w_acc;
    logic           w_cnt_hit;
    logic           w_close;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_p0;
    logic [2*W-1:0] w_p1;
    logic [W-1:0]   w_t0;
    logic [W-1:0]   w_t1;
    logic [W:0]     w_sum;

    // Whole pipeline moves together; it freezes only when a result is stuck.
    assign w_adv     = !r_out_valid || out_ready;
    // Gated with RST_N so nothing is accepted while reset is asserted.
    assign in_ready  = RST_N && w_adv && !r_flush_pending;
    assign w_acc     = in_valid && in_ready;
    // Reaching the last cell without in_last forces the line closed.
    assign w_cnt_hit = (r_cnt == CW'(LINE_LEN - 1));
    assign w_close   = in_last || w_cnt_hit;

    // Sign-extended operands make the low 2W bits of the product the signed result.
    assign w_diff = {r_is_ezr[W-1], r_is_ezr} - {r_is_ezh[W-1], r_is_ezh};
    assign w_p0   = {{W{chyh[W-1]}}, chyh} * {{W{r_s1_hy[W-1]}}, r_s1_hy};
    assign w_p1   = {{W{chyez[W-1]}}, chyez} * {{W{r_s1_d[W-1]}}, r_s1_d};
    assign w_t0   = trunc_p(r_s2_p0);
    assign w_t1   = trunc_p(r_s2_p1);
    assign w_sum  = {w_t0[W-1], w_t0} + {w_t1[W-1], w_t1};

    // Hold register, beat counter, flush request and sticky length error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hold_vld      <= 1'b0;
            r_ez_h          <= '0;
            r_hy_h          <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
            r_line_err      <= 1'b0;
        end else begin
            if (w_acc) begin
                r_ez_h     <= Ez_i;
                r_hy_h     <= Hy_old_i;
                r_hold_vld <= 1'b1;
                if (w_close) begin
                    r_cnt           <= '0;
                    r_flush_pending <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                // Error when in_last and the count disagree in either direction.
                if (in_last != w_cnt_hit) begin
                    r_line_err <= 1'b1;
                end
            end else if (r_flush_pending && w_adv) begin
                r_flush_pending <= 1'b0;
                r_hold_vld      <= 1'b0;
            end
        end
    end

    // Issue: a new beat releases the held cell; a flush releases it against Ez=0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_is_vld  <= 1'b0;
            r_is_last <= 1'b0;
            r_is_ezr  <= '0;
            r_is_ezh  <= '0;
            r_is_hy   <= '0;
        end else if (w_adv) begin
            if (w_acc && r_hold_vld) begin
                r_is_vld  <= 1'b1;
                r_is_last <= 1'b0;
                r_is_ezr  <= Ez_i;
                r_is_ezh  <= r_ez_h;
                r_is_hy   <= r_hy_h;
            end else if (r_flush_pending) begin
                r_is_vld  <= 1'b1;
                r_is_last <= 1'b1;
                r_is_ezr  <= '0;
                r_is_ezh  <= r_ez_h;
                r_is_hy   <= r_hy_h;
            end else begin
                r_is_vld  <= 1'b0;
                r_is_last <= 1'b0;
            end
        end
    end

    // S1 and S2: saturating curl difference, then both full-width products.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_d    <= '0;
            r_s1_hy   <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_p0   <= '0;
            r_s2_p1   <= '0;
        end else if (w_adv) begin
            r_s1_vld  <= r_is_vld;
            r_s1_last <= r_is_last;
            r_s1_d    <= sat_w(w_diff);
            r_s1_hy   <= r_is_hy;
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_s2_p0   <= w_p0;
            r_s2_p1   <= w_p1;
        end
    end

    // S3: slice, add and saturate into the output register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_hy_n      <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_vld;
            r_out_last  <= r_s2_vld && r_s2_last;
            if (r_s2_vld) begin
                r_hy_n <= sat_w(w_sum);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign Hy_n_o    = r_hy_n;
    assign line_err  = r_line_err;

endmodule

// File: tb/tb_fdtd_calc_hy.sv
// ---------------------------------------------------------------------------
// tb_fdtd_calc_hy
// Scoreboard bench for fdtd_calc_hy with LINE_LEN = 4. Expected results are
// computed from a behavioural model when a line is queued and compared when
// the DUT hands a result over.
// ---------------------------------------------------------------------------
module tb_fdtd_calc_hy;

    localparam int LL = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] Ez_i;
    logic [31:0] Hy_old_i;
    logic [31:0] chyh;
    logic [31:0] chyez;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] Hy_n_o;
    logic        line_err;

    fdtd_calc_hy #(
        .FDTD_DATA_WIDTH(32),
        .CUT_LT(51),
        .CUT_RT(21),
        .LINE_LEN(LL)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .Ez_i(Ez_i), .Hy_old_i(Hy_old_i), .chyh(chyh), .chyez(chyez),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .Hy_n_o(Hy_n_o), .line_err(line_err)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] ez; logic [31:0] hy; logic last; int pos; } beat_t;
    typedef struct { logic [31:0] v; logic last; } res_t;

    beat_t drv_q[$];
    res_t  exp_q[$];
    logic [31:0] lez [8];
    logic [31:0] lhy [8];

    int total = 0;
    int bad   = 0;
    int step_n = 0;
    int or_mode = 0;
    logic [3:0] or_pat = 4'b1001;
    logic prev_stall = 1'b0;
    logic [31:0] prev_hy = 32'd0;
    logic prev_last = 1'b0;
    bit lat_on = 1'b0;
    int lat_mark = -1;
    int first_out = -1;
    int n_out = 0;
    int ir_low = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        logic [63:0] t;
        t = v;
        if (v > MAXV) return 32'h7FFFFFFF;
        else if (v < MINV) return 32'h80000000;
        else return t[31:0];
    endfunction

    // Reference: fixed point with 2^21 == 1.0, products floored by the shift.
    function automatic logic [31:0] model(input logic [31:0] ch, input logic [31:0] ce,
                                          input logic [31:0] hy, input logic [31:0] ezk,
                                          input logic [31:0] ezr);
        longint d, p0, p1;
        d  = longint'($signed(sat32(longint'($signed(ezr)) - longint'($signed(ezk)))));
        p0 = longint'($signed(ch)) * longint'($signed(hy));
        p1 = longint'($signed(ce)) * d;
        return sat32((p0 >>> 21) + (p1 >>> 21));
    endfunction

    // Queue n beats from lez/lhy and the n_res results the DUT should produce.
    task automatic queue_line(input int n, input bit mark_last, input int n_res);
        beat_t b;
        res_t  r;
        logic [31:0] ezr;
        for (int k = 0; k < n; k++) begin
            b.ez = lez[k]; b.hy = lhy[k]; b.pos = k;
            b.last = mark_last && (k == n - 1);
            drv_q.push_back(b);
        end
        for (int k = 0; k < n_res; k++) begin
            ezr = (k == n_res - 1) ? 32'd0 : lez[k+1];
            r.v = model(chyh, chyez, lhy[k], lez[k], ezr);
            r.last = (k == n_res - 1);
            exp_q.push_back(r);
        end
    endtask

    task automatic step();
        res_t r;
        @(negedge CLK);
        step_n++;
        out_ready = (or_mode == 0) ? 1'b1 : or_pat[step_n % 4];
        if (drv_q.size() > 0) begin
            in_valid = 1'b1; Ez_i = drv_q[0].ez; Hy_old_i = drv_q[0].hy; in_last = drv_q[0].last;
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
        #1;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", Hy_n_o, prev_hy);
            chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        prev_stall = out_valid && !out_ready;
        prev_hy    = Hy_n_o;
        prev_last  = out_last;
        if (out_valid && lat_on && first_out < 0) first_out = step_n;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 32'(exp_q.size()), 32'd1);
            end else begin
                r = exp_q.pop_front();
                chk("hy", Hy_n_o, r.v);
                chk("last", 32'(out_last), 32'(r.last));
                n_out++;
            end
        end
        if (!in_ready) ir_low++;
        if (in_valid && in_ready) begin
            if (lat_on && drv_q[0].pos == 1) lat_mark = step_n;
            void'(drv_q.pop_front());
        end
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() > 0 || drv_q.size() > 0) && b < 300) begin
            step();
            b++;
        end
        if (b >= 300) chk("drain_timeout", 32'(exp_q.size() + drv_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        drv_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_hy", Hy_n_o, 32'd0);
        chk("rst_line_err", 32'(line_err), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic set_basic();
        lez[0] = 32'd10; lez[1] = 32'd20; lez[2] = 32'd40; lez[3] = 32'd80;
        lhy[0] = 32'd1;  lhy[1] = 32'd2;  lhy[2] = 32'd3;  lhy[3] = 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; in_last = 1'b0; Ez_i = 32'd0; Hy_old_i = 32'd0;
        out_ready = 1'b1;
        chyh = 32'h00200000; chyez = 32'h00200000;
        repeat (2) @(negedge CLK);
        do_reset();

        // Basic line with known values and first-result latency.
        set_basic();
        chk("model_basic3", model(chyh, chyez, 32'd4, 32'd80, 32'd0), 32'hFFFFFFB4);
        lat_on = 1'b1;
        queue_line(4, 1'b1, 4);
        drain();
        lat_on = 1'b0;
        chk("latency", 32'(first_out - lat_mark - 1), 32'd3);

        // Saturation of the sum and a negative curl term.
        lez[0] = 32'd0; lez[1] = 32'd100; lez[2] = 32'd0; lez[3] = 32'd0;
        lhy[0] = 32'h7FFFFFF0; lhy[1] = 32'd0; lhy[2] = 32'd0; lhy[3] = 32'd0;
        queue_line(4, 1'b1, 4);
        drain();

        // Non-unit coefficients (0.5 and 2.0) with mixed signs.
        chyh = 32'h00100000; chyez = 32'h00400000;
        lez[0] = 32'd5; lez[1] = -32'sd7; lez[2] = 32'd3; lez[3] = 32'd100;
        lhy[0] = 32'd9; lhy[1] = -32'sd9; lhy[2] = 32'd1000; lhy[3] = 32'd0;
        queue_line(4, 1'b1, 4);
        drain();
        chyh = 32'h00200000; chyez = 32'h00200000;

        // Backpressure with out_ready cycling 1,0,0,1.
        set_basic();
        n_out = 0;
        or_mode = 1;
        queue_line(4, 1'b1, 4);
        drain();
        or_mode = 0;
        chk("bp_count", 32'(n_out), 32'd4);

        // Two back-to-back lines: one in_ready bubble per flush.
        n_out = 0;
        ir_low = 0;
        queue_line(4, 1'b1, 4);
        lez[0] = 32'd7; lez[1] = 32'd3; lez[2] = -32'sd50; lez[3] = 32'd1;
        lhy[0] = 32'd100; lhy[1] = -32'sd100; lhy[2] = 32'd0; lhy[3] = 32'd5;
        queue_line(4, 1'b1, 4);
        while (drv_q.size() > 0 && ir_low < 50) step();
        step();
        chk("b2b_bubbles", 32'(ir_low), 32'd2);
        drain();
        chk("b2b_count", 32'(n_out), 32'd8);
        chk("no_err", 32'(line_err), 32'd0);

        // Short line: in_last on beat 2.
        set_basic();
        queue_line(3, 1'b1, 3);
        drain();
        chk("short_err", 32'(line_err), 32'd1);
        do_reset();

        // Long line: five beats without in_last, forced flush after beat 4.
        lez[4] = 32'd33; lhy[4] = 32'd44;
        queue_line(5, 1'b0, 4);
        drain();
        chk("long_err", 32'(line_err), 32'd1);

        // Reset in the middle of a line discards everything.
        queue_line(2, 1'b0, 0);
        while (drv_q.size() > 0 && step_n < 90000) step();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end
        set_basic();
        n_out = 0;
        queue_line(4, 1'b1, 4);
        drain();
        chk("post_rst_count", 32'(n_out), 32'd4);
        chk("post_rst_err", 32'(line_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
